// File: rtl/sram_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of a single SRAM controller slave.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed M0 priority.
module sram_wb_arbiter #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int CTAG_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  m0_CYC_I,
  input  logic                  m0_STB_I,
  input  logic                  m0_WE_I,
  input  logic                  m0_LOCK_I,
  input  logic [ADDR_WIDTH-1:0] m0_ADR_I,
  input  logic [DATA_WIDTH-1:0] m0_DAT_I,
  input  logic [CTAG_WIDTH-1:0] m0_TGC_I,
  output logic [DATA_WIDTH-1:0] m0_DAT_O,
  output logic                  m0_ACK_O,
  output logic                  m0_ERR_O,
  input  logic                  m1_CYC_I,
  input  logic                  m1_STB_I,
  input  logic                  m1_WE_I,
  input  logic                  m1_LOCK_I,
  input  logic [ADDR_WIDTH-1:0] m1_ADR_I,
  input  logic [DATA_WIDTH-1:0] m1_DAT_I,
  input  logic [CTAG_WIDTH-1:0] m1_TGC_I,
  output logic [DATA_WIDTH-1:0] m1_DAT_O,
  output logic                  m1_ACK_O,
  output logic                  m1_ERR_O,
  output logic                  s_CYC_O,
  output logic                  s_STB_O,
  output logic                  s_WE_O,
  output logic [ADDR_WIDTH-1:0] s_ADR_O,
  output logic [DATA_WIDTH-1:0] s_DAT_O,
  output logic [CTAG_WIDTH-1:0] s_TGC_O,
  input  logic [DATA_WIDTH-1:0] s_DAT_I,
  input  logic                  s_ACK_I,
  input  logic                  s_ERR_I,
  output logic [1:0]            gnt_o,
  output logic [1:0]            dbg_state_o
);

  // Wishbone handshake: a beat completes on a cycle with CYC & STB & (ACK | ERR); the
  // owning requester holds ADR/DAT/WE/TGC stable until that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2, FLUSH = 2'd3} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_m1_q, flush_m1_d;

  logic own_m1, own_cyc, own_stb, own_lock, granted, stall, timeout, tie_m1, pick_m1;

  assign own_m1   = (state_q == GRANT1) || ((state_q == FLUSH) && flush_m1_q);
  assign own_cyc  = own_m1 ? m1_CYC_I  : m0_CYC_I;
  assign own_stb  = own_m1 ? m1_STB_I  : m0_STB_I;
  assign own_lock = own_m1 ? m1_LOCK_I : m0_LOCK_I;
  assign granted  = (state_q == GRANT0) || (state_q == GRANT1);
  assign stall    = granted && own_cyc && own_stb && !s_ACK_I && !s_ERR_I;
  assign timeout  = stall && (cnt_q == CNT_LAST);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_m1_q, last_m1_d;
  assign tie_m1 = ~last_m1_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) last_m1_q <= 1'b1;
    else       last_m1_q <= last_m1_d;
  end
`else
  assign tie_m1 = 1'b0;
`endif

  assign pick_m1 = m1_CYC_I && (!m0_CYC_I || tie_m1);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      cnt_q      <= '0;
      flush_m1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      flush_m1_q <= flush_m1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = '0;
    flush_m1_d = flush_m1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_m1_d  = last_m1_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_CYC_I || m1_CYC_I) begin
          state_d = pick_m1 ? GRANT1 : GRANT0;
          gnt_d   = pick_m1 ? 2'b10 : 2'b01;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          last_m1_d = pick_m1;
`endif
        end
      end
      GRANT0, GRANT1: begin
        if (timeout) begin
          state_d    = FLUSH;
          gnt_d      = 2'b00;
          flush_m1_d = own_m1;
        end else if (!own_cyc && !own_lock) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (stall) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A locked requester with CYC low keeps the grant but the slave sees no cycle.
  always_comb begin
    s_CYC_O  = 1'b0;
    s_STB_O  = 1'b0;
    s_WE_O   = 1'b0;
    s_ADR_O  = '0;
    s_DAT_O  = '0;
    s_TGC_O  = '0;
    m0_ACK_O = 1'b0;
    m0_ERR_O = 1'b0;
    m0_DAT_O = '0;
    m1_ACK_O = 1'b0;
    m1_ERR_O = 1'b0;
    m1_DAT_O = '0;
    if (granted) begin
      s_CYC_O = own_cyc;
      s_STB_O = own_cyc && own_stb;
      s_WE_O  = own_m1 ? m1_WE_I  : m0_WE_I;
      s_ADR_O = own_m1 ? m1_ADR_I : m0_ADR_I;
      s_DAT_O = own_m1 ? m1_DAT_I : m0_DAT_I;
      s_TGC_O = own_m1 ? m1_TGC_I : m0_TGC_I;
      if (own_m1) begin
        m1_ACK_O = s_ACK_I;
        m1_ERR_O = s_ERR_I || timeout;
        m1_DAT_O = s_DAT_I;
      end else begin
        m0_ACK_O = s_ACK_I;
        m0_ERR_O = s_ERR_I || timeout;
        m0_DAT_O = s_DAT_I;
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Self-checking bench for sram_wb_arbiter: behavioural SRAM slave plus request/expected-data scoreboard.
module tb_sram_wb_arbiter;

  localparam logic [1:0] SR_CYC_SRD  = 2'd0;
  localparam logic [1:0] SR_CYC_SWRT = 2'd1;
  localparam logic [1:0] SR_CYC_BRD1 = 2'd2;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m0_lock, m1_cyc, m1_stb, m1_we, m1_lock;
  logic [19:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat;
  logic [1:0]  m0_tgc, m1_tgc;
  logic [7:0]  m0_DAT_O, m1_DAT_O, s_DAT_O, s_DAT_I;
  logic        m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O;
  logic        s_CYC_O, s_STB_O, s_WE_O, s_ACK_I, s_ERR_I;
  logic [19:0] s_ADR_O;
  logic [1:0]  s_TGC_O, gnt_o, dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [30:0] req_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  slave_mem[logic [19:0]];
  logic [7:0]  model_mem[logic [19:0]];
  logic        slave_en, slave_err, slave_spur;
  logic        tb_last;

  sram_wb_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .CTAG_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
    .CLK_I(clk), .RST_I(rst),
    .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we), .m0_LOCK_I(m0_lock),
    .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_TGC_I(m0_tgc),
    .m0_DAT_O(m0_DAT_O), .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
    .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we), .m1_LOCK_I(m1_lock),
    .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_TGC_I(m1_tgc),
    .m1_DAT_O(m1_DAT_O), .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
    .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O),
    .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_TGC_O(s_TGC_O),
    .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .s_ERR_I(s_ERR_I),
    .gnt_o(gnt_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt_rd(input logic [19:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] model_rd(input logic [19:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt_rd(a);
  endfunction

  // driver tasks
  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic lock, input logic [19:0] adr, input logic [7:0] dat,
                         input logic [1:0] tgc);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_lock = lock;
      m0_adr = adr; m0_dat = dat; m0_tgc = tgc;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_lock = lock;
      m1_adr = adr; m1_dat = dat; m1_tgc = tgc;
    end
  endtask

  task automatic drop(input int m);
    drive_m(m, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 2'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: raise CYC, confirm no grant yet, then exactly one edge later the grant.
  task automatic request(input int m, input logic we, input logic [19:0] adr,
                         input logic [7:0] dat, input logic [1:0] tgc);
    drive_m(m, 1'b1, 1'b1, we, 1'b0, adr, dat, tgc);
    @(negedge clk);
    check_eq("gnt_before_edge", 32'(gnt_o), 32'd0);
    next_cycle();
    check_eq("gnt_after_edge", 32'(gnt_o), (m == 0) ? 32'd1 : 32'd2);
    tb_last = (m != 0);
  endtask

  // One beat by the granted requester; returns at posedge+1 after the response cycle.
  task automatic xfer(input int m, input logic we, input logic [19:0] adr,
                      input logic [7:0] dat, input logic [1:0] tgc, input logic exp_err);
    logic       ack, err, seen;
    logic [7:0] got_d, exp_d;
    logic [9:0] other;
    ack = 1'b0; err = 1'b0; seen = 1'b0; got_d = 8'h0;
    drive_m(m, 1'b1, 1'b1, we, 1'b0, adr, dat, tgc);
    req_q.push_back({we, tgc, adr, dat});
    if (!exp_err) begin
      if (we) model_mem[adr] = dat;
      else    exp_q.push_back(model_rd(adr));
    end
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      other = (m == 0) ? {m1_ACK_O, m1_ERR_O, m1_DAT_O} : {m0_ACK_O, m0_ERR_O, m0_DAT_O};
      check_eq("other_quiet", 32'(other), 32'd0);
      ack   = (m == 0) ? m0_ACK_O : m1_ACK_O;
      err   = (m == 0) ? m0_ERR_O : m1_ERR_O;
      got_d = (m == 0) ? m0_DAT_O : m1_DAT_O;
      if (ack || err) seen = 1'b1;
    end
    check_eq("resp_seen", 32'(seen), 32'd1);
    check_eq("resp_kind", 32'({ack, err}), 32'({!exp_err, exp_err}));
    if (ack && !we && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      check_eq("rd_data", 32'(got_d), 32'(exp_d));
    end
    next_cycle();
  endtask

  // behavioural SRAM slave: one wait state, checks each accepted request against req_q
  initial begin
    logic        go, we_l;
    logic [7:0]  rdat;
    logic [30:0] r;
    s_ACK_I = 1'b0; s_ERR_I = 1'b0; s_DAT_I = 8'h0;
    we_l = 1'b0; rdat = 8'h0;
    forever begin
      @(negedge clk);
      go = s_CYC_O && s_STB_O && !s_ACK_I && !s_ERR_I && slave_en && !slave_spur && !rst;
      if (go) begin
        check_eq("slave_q_depth", 32'(req_q.size()), 32'd1);
        if (req_q.size() > 0) begin
          r = req_q.pop_front();
          check_eq("slave_req", 32'({s_WE_O, s_TGC_O, s_ADR_O, s_DAT_O}), 32'(r));
        end
        rdat = slave_mem.exists(s_ADR_O) ? slave_mem[s_ADR_O] : dflt_rd(s_ADR_O);
        we_l = s_WE_O;
        if (s_WE_O && !slave_err) slave_mem[s_ADR_O] = s_DAT_O;
      end
      @(posedge clk);
      #1;
      s_ACK_I = slave_spur || (go && !slave_err);
      s_ERR_I = slave_spur || (go && slave_err);
      s_DAT_I = slave_spur ? 8'hFF : ((go && !we_l && !slave_err) ? rdat : 8'h00);
    end
  end

  initial begin
    logic win;
    rst = 1'b1;
    drop(0); drop(1);
    slave_en = 1'b1; slave_err = 1'b0; slave_spur = 1'b0; tb_last = 1'b1;

    // reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 32'(gnt_o), 32'd0);
    check_eq("rst_state", 32'(dbg_state_o), 32'd0);
    check_eq("rst_outs", 32'({s_CYC_O, s_STB_O, m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O}), 32'd0);
    next_cycle();
    rst = 1'b0;

    // slave responses in IDLE are ignored
    @(negedge clk);
    slave_spur = 1'b1;
    @(negedge clk);
    check_eq("idle_spur", 32'({m0_ACK_O, m0_ERR_O, m0_DAT_O, m1_ACK_O, m1_ERR_O, m1_DAT_O}), 32'd0);
    slave_spur = 1'b0;
    next_cycle();
    next_cycle();

    // M0 single write, address/data passed straight through
    request(0, 1'b1, 20'h01777, 8'hC9, SR_CYC_SWRT);
    check_eq("w_s_adr", 32'(s_ADR_O), 32'h01777);
    check_eq("w_s_dat", 32'(s_DAT_O), 32'hC9);
    check_eq("w_s_ctl", 32'({s_CYC_O, s_STB_O, s_WE_O, s_TGC_O}), 32'({3'b111, SR_CYC_SWRT}));
    xfer(0, 1'b1, 20'h01777, 8'hC9, SR_CYC_SWRT, 1'b0);
    drop(0);
    @(negedge clk);
    check_eq("w_release_cyc", 32'({gnt_o, s_CYC_O}), 32'({2'b01, 1'b0}));
    next_cycle();
    check_eq("w_back_idle", 32'({gnt_o, dbg_state_o}), 32'd0);

    // simultaneous requests from IDLE, twice
    for (int t = 0; t < 2; t++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      win = !tb_last;
`else
      win = 1'b0;
`endif
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00100 + 20'(t), 8'h0, SR_CYC_SRD);
      drive_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00200 + 20'(t), 8'h0, SR_CYC_SRD);
      @(negedge clk);
      check_eq("tie_gnt_lat", 32'(gnt_o), 32'd0);
      next_cycle();
      check_eq("tie_gnt", 32'(gnt_o), win ? 32'd2 : 32'd1);
      tb_last = win;
      xfer(win ? 1 : 0, 1'b0, win ? 20'h00200 + 20'(t) : 20'h00100 + 20'(t), 8'h0, SR_CYC_SRD, 1'b0);
      drop(0); drop(1);
      next_cycle();
      next_cycle();
    end

    // M1 block read holds off M0; M0 granted two edges after M1 drops CYC
    request(1, 1'b0, 20'h09999, 8'h0, SR_CYC_BRD1);
    xfer(1, 1'b0, 20'h09999, 8'h0, SR_CYC_BRD1, 1'b0);
    drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h01777, 8'h0, SR_CYC_SRD);
    xfer(1, 1'b0, 20'h0999A, 8'h0, SR_CYC_BRD1, 1'b0);
    check_eq("hold_gnt", 32'(gnt_o), 32'd2);
    drop(1);
    @(negedge clk);
    check_eq("hold_edge0", 32'(gnt_o), 32'd2);
    next_cycle();
    check_eq("hold_edge1", 32'(gnt_o), 32'd0);
    next_cycle();
    check_eq("hold_edge2", 32'(gnt_o), 32'd1);
    tb_last = 1'b0;
    xfer(0, 1'b0, 20'h01777, 8'h0, SR_CYC_SRD, 1'b0);
    drop(0);
    next_cycle();

    // locked grant survives CYC low; slave sees no cycle
    request(0, 1'b1, 20'h06000, 8'h5A, SR_CYC_SWRT);
    xfer(0, 1'b1, 20'h06000, 8'h5A, SR_CYC_SWRT, 1'b0);
    drive_m(0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0, 8'h0, 2'b0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h06000, 8'h0, SR_CYC_SRD);
    @(negedge clk);
    check_eq("lock_hold0", 32'({gnt_o, s_CYC_O, s_STB_O, dbg_state_o}), 32'({2'b01, 2'b00, 2'd1}));
    next_cycle();
    @(negedge clk);
    check_eq("lock_hold1", 32'(gnt_o), 32'd1);
    next_cycle();
    drop(0);
    @(negedge clk);
    check_eq("lock_hold2", 32'(gnt_o), 32'd1);
    next_cycle();
    check_eq("unlock_idle", 32'(gnt_o), 32'd0);
    next_cycle();
    check_eq("unlock_m1", 32'(gnt_o), 32'd2);
    tb_last = 1'b1;
    xfer(1, 1'b0, 20'h06000, 8'h0, SR_CYC_SRD, 1'b0);
    drop(1);
    next_cycle();

    // timeout after 8 unacknowledged strobe cycles, then FLUSH until CYC drops
    slave_en = 1'b0;
    request(0, 1'b0, 20'h04444, 8'h0, SR_CYC_SRD);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("to_err_c%0d", k), 32'(m0_ERR_O), 32'(k == 8));
      if (k == 8) slave_spur = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    check_eq("flush_bus", 32'({s_CYC_O, s_STB_O, m0_ACK_O, m0_ERR_O, gnt_o}), 32'd0);
    check_eq("flush_state", 32'(dbg_state_o), 32'd3);
    next_cycle();
    @(negedge clk);
    check_eq("flush_hold", 32'({dbg_state_o, m0_ACK_O, m0_ERR_O}), 32'({2'd3, 2'b00}));
    slave_spur = 1'b0;
    next_cycle();
    drop(0);
    @(negedge clk);
    check_eq("flush_cyc_low", 32'(dbg_state_o), 32'd3);
    next_cycle();
    check_eq("flush_exit", 32'(dbg_state_o), 32'd0);
    @(negedge clk);
    slave_en = 1'b1;
    next_cycle();

    // slave ERR on M1 read goes to M1 only; a following M0 read works
    slave_err = 1'b1;
    request(1, 1'b0, 20'h02222, 8'h0, SR_CYC_SWRT);
    xfer(1, 1'b0, 20'h02222, 8'h0, SR_CYC_SWRT, 1'b1);
    drop(1);
    slave_err = 1'b0;
    next_cycle();
    request(0, 1'b0, 20'h01111, 8'h0, SR_CYC_SRD);
    xfer(0, 1'b0, 20'h01111, 8'h0, SR_CYC_SRD, 1'b0);
    drop(0);
    next_cycle();

    // asynchronous reset during an M1 block read
    request(1, 1'b0, 20'h03000, 8'h0, SR_CYC_BRD1);
    xfer(1, 1'b0, 20'h03000, 8'h0, SR_CYC_BRD1, 1'b0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h03001, 8'h0, SR_CYC_BRD1);
    req_q.push_back({1'b0, SR_CYC_BRD1, 20'h03001, 8'h0});
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_bus", 32'({s_CYC_O, s_STB_O, gnt_o, dbg_state_o}), 32'd0);
    drop(0); drop(1);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    tb_last = 1'b1;
    next_cycle();
    request(0, 1'b1, 20'h05000, 8'h3C, SR_CYC_SWRT);
    xfer(0, 1'b1, 20'h05000, 8'h3C, SR_CYC_SWRT, 1'b0);
    drop(0);
    next_cycle();
    request(0, 1'b0, 20'h05000, 8'h0, SR_CYC_SRD);
    xfer(0, 1'b0, 20'h05000, 8'h0, SR_CYC_SRD, 1'b0);
    drop(0);
    next_cycle();
    next_cycle();

    check_eq("req_q_drained", 32'(req_q.size()), 32'd0);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_wb_arbiter.md
SRAM_WB_ARBITER -- requirements
Module: sram_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, address width of all ADR ports.
REQ-002 Parameter DATA_WIDTH, default 8, width of all data ports.
REQ-003 Parameter CTAG_WIDTH, default 2, width of the cycle-tag (SR_CYC_*) ports.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, maximum number of strobe cycles without slave ACK/ERR.
REQ-005 CLK_I  in  1  the single system clock; all state changes on its rising edge.
REQ-006 RST_I  in  1  reset, asynchronous and active-high.
REQ-007 mN_CYC_I, mN_STB_I, mN_WE_I, mN_LOCK_I  in  1 each  Wishbone cycle, strobe, write and lock from requester N (N = 0, 1).
REQ-008 mN_ADR_I  in  ADDR_WIDTH  address from requester N.
REQ-009 mN_DAT_I  in  DATA_WIDTH  write data from requester N.
REQ-010 mN_TGC_I  in  CTAG_WIDTH  cycle tag from requester N.
REQ-011 mN_DAT_O  out  DATA_WIDTH  read data to requester N.
REQ-012 mN_ACK_O, mN_ERR_O  out  1 each  acknowledge and error to requester N.
REQ-013 s_CYC_O, s_STB_O, s_WE_O  out  1 each  cycle, strobe and write to the SRAM controller.
REQ-014 s_ADR_O, s_DAT_O, s_TGC_O  out  ADDR_WIDTH, DATA_WIDTH, CTAG_WIDTH  address, write data and cycle tag to the SRAM controller.
REQ-015 s_DAT_I, s_ACK_I, s_ERR_I  in  DATA_WIDTH, 1, 1  read data, acknowledge and error from the SRAM controller.
REQ-016 gnt_o  out  2  registered one-hot grant: 01 = M0, 10 = M1, 00 = none.

Function
REQ-017 The arbiter SHALL implement the states IDLE, GRANT0, GRANT1 and FLUSH.
REQ-018 In IDLE: s_CYC_O and s_STB_O = 0; all mN_ACK_O, mN_ERR_O = 0; all mN_DAT_O = 0.
REQ-019 IDLE -> GRANTn on the edge where mN_CYC_I = 1; grant latency is exactly 1 cycle; a simultaneous request is resolved per REQ-031/REQ-032.
REQ-020 In GRANTn, s_CYC_O, s_STB_O, s_WE_O, s_ADR_O, s_DAT_O and s_TGC_O SHALL combinationally follow requester N's inputs.
REQ-021 In GRANTn, s_ACK_I, s_ERR_I and s_DAT_I SHALL route only to requester N; the other requester sees ACK = ERR = 0 and DAT = 0.
REQ-022 No preemption: GRANTn SHALL hold while mN_CYC_I = 1, regardless of the other requester.
REQ-023 GRANTn -> IDLE on the edge where mN_CYC_I = 0 and mN_LOCK_I = 0; at least one IDLE cycle SHALL separate consecutive grants.
REQ-024 If mN_CYC_I = 0 with mN_LOCK_I = 1, GRANTn SHALL be held with s_CYC_O = 0 until mN_LOCK_I drops.
REQ-025 A timeout counter SHALL increment each GRANTn cycle with mN_STB_I = 1 and s_ACK_I = s_ERR_I = 0, and SHALL clear on ACK, ERR, STB low, or leaving GRANTn.
REQ-026 When the counter reaches TIMEOUT_CYCLES, mN_ERR_O SHALL pulse for exactly that cycle and the state SHALL go to FLUSH.
REQ-027 In FLUSH: s_CYC_O = s_STB_O = 0; mN_ACK_O = mN_ERR_O = 0; the state returns to IDLE on the edge after mN_CYC_I = 0.
REQ-028 s_ACK_I or s_ERR_I arriving in IDLE or FLUSH SHALL be ignored.
REQ-029 The arbiter SHALL NOT inspect or validate the cycle tag; tag/WE mismatches are reported by the slave's ERR, which is routed per REQ-021.

Reset
REQ-030 While RST_I = 1, immediately and asynchronously: state = IDLE, gnt_o = 00, timeout counter = 0, last-granted = M1, and all outputs are 0.

Configuration
REQ-031 With SRAM_ARB_ROUND_ROBIN_EN defined, on a simultaneous request in IDLE the grant goes to the requester not granted last; after reset M0 wins the first tie.
REQ-032 Without SRAM_ARB_ROUND_ROBIN_EN, the arbiter uses fixed priority and M0 always wins a tie; the last-granted register is not built.

Verification
REQ-033 RST_I held for 4 cycles; M0 performs a write with ADR 1777, DAT C9 and TGC SR_CYC_SWRT -> gnt_o = 01 one cycle after CYC; s_ADR_O = 1777; s_DAT_O = C9; m0_ACK_O mirrors s_ACK_I; m1_ACK_O = 0 throughout.
REQ-034 Both requesters assert CYC in the same cycle from IDLE, twice in succession -> with the macro defined, the grants are M0 then M1; without the macro, both grants go to M0.
REQ-035 M1 holds a block read (SR_CYC_BRD1, ADR 9999) while M0 requests -> M0 is held off; gnt_o = 01 exactly 2 edges after m1_CYC_I falls.
REQ-036 TIMEOUT_CYCLES = 8 and s_ACK_I stuck at 0 -> m0_ERR_O pulses on the 8th strobe cycle; s_CYC_O = 0 the next cycle; the state returns to IDLE only after m0_CYC_I drops.
REQ-037 M1 issues a read (WE = 0) with TGC SR_CYC_SWRT, ADR 2222, and the slave returns ERR -> m1_ERR_O = 1 and m0_ERR_O = 0; after m1_CYC_I falls, a following M0 read of ADR 1111 completes normally.
REQ-038 RST_I asserted mid-way through a GRANT1 block read -> s_CYC_O, s_STB_O and gnt_o go to 0 in the same timestep; after release, the first request is granted normally.
